// File: rtl/fp_wb_sched_pkg.sv
// Shared types and constants for the FP writeback scheduler.
package fp_wb_pkg;

  localparam int NUM_FP_REGS = 32;
  localparam int FP_ADDR_W   = 5;
  localparam int FP_DATA_W   = 16;

  typedef logic [FP_ADDR_W-1:0] fp_addr_t;

  typedef struct packed {
    fp_addr_t               addr;
    logic [FP_DATA_W-1:0]   data;
  } wb_req_t;

  // Wrap a rotated source index back into 0..n-1 (idx is always below 2*n).
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/fp_wb_sched_if.sv
// Bus bundle between the writeback producers/issue stage and the scheduler.
interface fp_wb_sched_if
  import fp_wb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = FP_DATA_W,
  parameter int ADDR_W  = FP_ADDR_W
);

  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*ADDR_W-1:0] src_addr;
  logic [NUM_SRC*DATA_W-1:0] src_data;

  logic                      issue_valid;
  logic [ADDR_W-1:0]         issue_addr;
  logic                      issue_ready;
  logic                      flush;

  logic [NUM_FP_REGS-1:0]    busy_vec;

  logic                      we0;
  logic [ADDR_W-1:0]         waddr0;
  logic [DATA_W-1:0]         wdata0;
  logic                      we1;
  logic [ADDR_W-1:0]         waddr1;
  logic [DATA_W-1:0]         wdata1;

  logic                      wb_err;

  modport master (
    output src_valid, src_addr, src_data, issue_valid, issue_addr, flush,
    input  src_ready, issue_ready, busy_vec,
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, wb_err
  );

  modport slave (
    input  src_valid, src_addr, src_data, issue_valid, issue_addr, flush,
    output src_ready, issue_ready, busy_vec,
    output we0, waddr0, wdata0, we1, waddr1, wdata1, wb_err
  );

endinterface

// File: rtl/fp_wb_sched_rr_pick2.sv
// Rotating two-grant picker: first valid source from ptr gets grant A, the next
// valid source whose destination differs from A's gets grant B.
module rr_pick2
  import fp_wb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  input  logic [NUM_SRC-1:0] conflict [NUM_SRC],
  output logic [NUM_SRC-1:0] gnt_a,
  output logic [NUM_SRC-1:0] gnt_b,
  output logic               vld_a,
  output logic               vld_b,
  output logic [IDX_W-1:0]   idx_a,
  output logic [IDX_W-1:0]   idx_b
);

  int               scan_idx;
  logic [IDX_W-1:0] cur;

  // Walk the sources in rotated order and take the first two compatible requesters.
  always_comb begin
    vld_a    = 1'b0;
    vld_b    = 1'b0;
    idx_a    = '0;
    idx_b    = '0;
    scan_idx = 0;
    cur      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_idx = rr_wrap(int'(ptr) + k, NUM_SRC);
      cur      = IDX_W'(scan_idx);
      if (valid[cur]) begin
        if (!vld_a) begin
          vld_a = 1'b1;
          idx_a = cur;
        end else if (!vld_b && !conflict[idx_a][cur]) begin
          vld_b = 1'b1;
          idx_b = cur;
        end
      end
    end
    gnt_a = vld_a ? (NUM_SRC'(1) << idx_a) : '0;
    gnt_b = vld_b ? (NUM_SRC'(1) << idx_b) : '0;
  end

endmodule

// File: rtl/fp_wb_sched.sv
// FP writeback scheduler: round-robin arbitration of producers onto the two
// regfile write ports, a one-cycle write stage, and the busy scoreboard.
module fp_wb_sched
  import fp_wb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = FP_DATA_W,
  parameter int ADDR_W  = FP_ADDR_W
) (
  input logic         clk,
  input logic         rst_n,
  fp_wb_sched_if.slave bus
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [ADDR_W-1:0]      s_addr [NUM_SRC];
  logic [DATA_W-1:0]      s_data [NUM_SRC];
  logic [NUM_SRC-1:0]     conflict [NUM_SRC];

  logic [NUM_SRC-1:0]     gnt_a, gnt_b;
  logic                   vld_a, vld_b;
  logic [IDX_W-1:0]       idx_a, idx_b;
  logic [IDX_W-1:0]       rr_ptr, last_idx, ptr_nxt;

  logic [ADDR_W-1:0]      addr_a, addr_b;

  logic                   we0_q, we1_q;
  logic [ADDR_W-1:0]      waddr0_q, waddr1_q;
  logic [DATA_W-1:0]      wdata0_q, wdata1_q;

  logic [NUM_FP_REGS-1:0] busy_q, busy_nxt;
  logic [NUM_FP_REGS-1:0] stale_q, stale_nxt;
  logic [NUM_FP_REGS-1:0] gnt_mask, commit_mask;
  logic                   issue_ready;
  logic                   err_hit;
  logic                   wb_err_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign s_addr[i] = bus.src_addr[i*ADDR_W +: ADDR_W];
    assign s_data[i] = bus.src_data[i*DATA_W +: DATA_W];
  end

  // Pairwise destination match; a source colliding with grant A must wait a cycle.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        conflict[i][j] = (s_addr[i] == s_addr[j]);
      end
    end
  end

  rr_pick2 #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid    (bus.src_valid),
    .ptr      (rr_ptr),
    .conflict (conflict),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .vld_a    (vld_a),
    .vld_b    (vld_b),
    .idx_a    (idx_a),
    .idx_b    (idx_b)
  );

  assign bus.src_ready = gnt_a | gnt_b;
  assign addr_a        = s_addr[idx_a];
  assign addr_b        = s_addr[idx_b];

  assign last_idx = vld_b ? idx_b : idx_a;
  assign ptr_nxt  = (last_idx == IDX_W'(NUM_SRC - 1)) ? '0 : last_idx + IDX_W'(1);

  // Rotate priority past the last source granted; hold when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             rr_ptr <= '0;
    else if (vld_a)         rr_ptr <= ptr_nxt;
  end

  // Write stage: granted results appear on the regfile ports one cycle later as single pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we0_q    <= 1'b0;
      we1_q    <= 1'b0;
      waddr0_q <= '0;
      waddr1_q <= '0;
      wdata0_q <= '0;
      wdata1_q <= '0;
    end else begin
      we0_q <= vld_a;
      we1_q <= vld_b;
      if (vld_a) begin
        waddr0_q <= addr_a;
        wdata0_q <= s_data[idx_a];
      end
      if (vld_b) begin
        waddr1_q <= addr_b;
        wdata1_q <= s_data[idx_b];
      end
    end
  end

  assign bus.we0    = we0_q;
  assign bus.waddr0 = waddr0_q;
  assign bus.wdata0 = wdata0_q;
  assign bus.we1    = we1_q;
  assign bus.waddr1 = waddr1_q;
  assign bus.wdata1 = wdata1_q;

  assign issue_ready     = ~busy_q[bus.issue_addr];
  assign bus.issue_ready = issue_ready;
  assign bus.busy_vec    = busy_q;

  // Masks of registers granted this cycle and registers committing this cycle.
  always_comb begin
    gnt_mask    = '0;
    commit_mask = '0;
    if (vld_a) gnt_mask[addr_a]      = 1'b1;
    if (vld_b) gnt_mask[addr_b]      = 1'b1;
    if (we0_q) commit_mask[waddr0_q] = 1'b1;
    if (we1_q) commit_mask[waddr1_q] = 1'b1;
  end

  // Scoreboard next state: commits clear, flush clears everything, an accepted issue sets (set beats clear).
  always_comb begin
    busy_nxt = busy_q & ~commit_mask;
    if (bus.flush)
      busy_nxt = '0;
    else if (bus.issue_valid && issue_ready)
      busy_nxt[bus.issue_addr] = 1'b1;
  end

  // Registers dropped by a flush whose write has not been granted yet; their late writeback is expected.
  always_comb begin
    stale_nxt = stale_q & ~gnt_mask;
    if (bus.flush)
      stale_nxt = stale_nxt | (busy_q & ~commit_mask & ~gnt_mask);
  end

  assign err_hit = (vld_a && !busy_q[addr_a] && !stale_q[addr_a]) ||
                   (vld_b && !busy_q[addr_b] && !stale_q[addr_b]);

  // Scoreboard, flushed-register tracking and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      stale_q  <= '0;
      wb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_nxt;
      stale_q  <= stale_nxt;
      wb_err_q <= wb_err_q | err_hit;
    end
  end

  assign bus.wb_err = wb_err_q;

endmodule

// File: tb/tb_fp_wb_sched.sv
// Directed, table-driven bench for fp_wb_sched with hand sequences for flush,
// issue stall, sticky error and asynchronous reset.
module tb_fp_wb_sched;
  import fp_wb_pkg::*;

  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 5;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_fail;

  fp_wb_sched_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  fp_wb_sched #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  v;
    logic [19:0] a;
    logic [63:0] d;
    logic        iv;
    fp_addr_t    ia;
    logic        fl;
    logic [3:0]  rdy;
    logic        ir;
    logic        we0;
    fp_addr_t    wa0;
    logic [15:0] wd0;
    logic        we1;
    fp_addr_t    wa1;
    logic [15:0] wd1;
    logic [31:0] busy;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [19:0] a, input logic [63:0] d,
                               input logic iv, input logic [4:0] ia, input logic fl);
    @(negedge clk);
    bus.src_valid   = v;
    bus.src_addr    = a;
    bus.src_data    = d;
    bus.issue_valid = iv;
    bus.issue_addr  = ia;
    bus.flush       = fl;
    #1;
  endtask

  task automatic idle();
    applyStimulus(4'h0, 20'h0, 64'h0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic addVec(input logic [3:0] v, input logic [19:0] a, input logic [63:0] d,
                        input logic iv, input logic [4:0] ia, input logic fl,
                        input logic [3:0] rdy, input logic ir,
                        input logic we0, input logic [4:0] wa0, input logic [15:0] wd0,
                        input logic we1, input logic [4:0] wa1, input logic [15:0] wd1,
                        input logic [31:0] busy, input logic err);
    vec_t t;
    t = '{v, a, d, iv, ia, fl, rdy, ir, we0, wa0, wd0, we1, wa1, wd1, busy, err};
    vecs.push_back(t);
  endtask

  task automatic checkRow(input int k, input vec_t t);
    checkOutput($sformatf("r%0d.ready", k), 32'(bus.src_ready), 32'(t.rdy));
    checkOutput($sformatf("r%0d.issue_ready", k), 32'(bus.issue_ready), 32'(t.ir));
    checkOutput($sformatf("r%0d.we0", k), 32'(bus.we0), 32'(t.we0));
    checkOutput($sformatf("r%0d.we1", k), 32'(bus.we1), 32'(t.we1));
    if (t.we0) begin
      checkOutput($sformatf("r%0d.waddr0", k), 32'(bus.waddr0), 32'(t.wa0));
      checkOutput($sformatf("r%0d.wdata0", k), 32'(bus.wdata0), 32'(t.wd0));
    end
    if (t.we1) begin
      checkOutput($sformatf("r%0d.waddr1", k), 32'(bus.waddr1), 32'(t.wa1));
      checkOutput($sformatf("r%0d.wdata1", k), 32'(bus.wdata1), 32'(t.wd1));
    end
    checkOutput($sformatf("r%0d.busy", k), bus.busy_vec, t.busy);
    checkOutput($sformatf("r%0d.wb_err", k), 32'(bus.wb_err), 32'(t.err));
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.src_valid   = '0;
    bus.src_addr    = '0;
    bus.src_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_addr  = '0;
    bus.flush       = 1'b0;

    // Issue r16..r23, then round-robin all four sources, single write r3, address conflict on r7.
    addVec(4'h0, 20'h0, 64'h0, 1, 5'd16, 0,  4'h0, 1, 0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 32'h0000_0000, 0);
    addVec(4'h0, 20'h0, 64'h0, 1, 5'd17, 0,  4'h0, 1, 0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 32'h0001_0000, 0);
    addVec(4'h0, 20'h0, 64'h0, 1, 5'd18, 0,  4'h0, 1, 0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 32'h0003_0000, 0);
    addVec(4'h0, 20'h0, 64'h0, 1, 5'd19, 0,  4'h0, 1, 0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 32'h0007_0000, 0);
    addVec(4'h0, 20'h0, 64'h0, 1, 5'd20, 0,  4'h0, 1, 0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 32'h000F_0000, 0);
    addVec(4'h0, 20'h0, 64'h0, 1, 5'd21, 0,  4'h0, 1, 0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 32'h001F_0000, 0);
    addVec(4'h0, 20'h0, 64'h0, 1, 5'd22, 0,  4'h0, 1, 0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 32'h003F_0000, 0);
    addVec(4'h0, 20'h0, 64'h0, 1, 5'd23, 0,  4'h0, 1, 0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 32'h007F_0000, 0);
    addVec(4'hF, {5'd19, 5'd18, 5'd17, 5'd16}, 64'h1003_1002_1001_1000, 0, 5'd0, 0,
           4'h3, 1, 0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 32'h00FF_0000, 0);
    addVec(4'hF, {5'd19, 5'd18, 5'd21, 5'd20}, 64'h1003_1002_1005_1004, 0, 5'd0, 0,
           4'hC, 1, 1, 5'd16, 16'h1000, 1, 5'd17, 16'h1001, 32'h00FF_0000, 0);
    addVec(4'hF, {5'd23, 5'd22, 5'd21, 5'd20}, 64'h1007_1006_1005_1004, 0, 5'd0, 0,
           4'h3, 1, 1, 5'd18, 16'h1002, 1, 5'd19, 16'h1003, 32'h00FC_0000, 0);
    addVec(4'hC, {5'd23, 5'd22, 5'd21, 5'd20}, 64'h1007_1006_1005_1004, 0, 5'd0, 0,
           4'hC, 1, 1, 5'd20, 16'h1004, 1, 5'd21, 16'h1005, 32'h00F0_0000, 0);
    addVec(4'h0, 20'h0, 64'h0, 0, 5'd0, 0,  4'h0, 1, 1, 5'd22, 16'h1006, 1, 5'd23, 16'h1007, 32'h00C0_0000, 0);
    addVec(4'h0, 20'h0, 64'h0, 0, 5'd0, 0,  4'h0, 1, 0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 32'h0000_0000, 0);
    addVec(4'h0, 20'h0, 64'h0, 1, 5'd3, 0,  4'h0, 1, 0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 32'h0000_0000, 0);
    addVec(4'h1, {5'd0, 5'd0, 5'd0, 5'd3}, 64'h0000_0000_0000_3C00, 0, 5'd0, 0,
           4'h1, 1, 0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 32'h0000_0008, 0);
    addVec(4'h0, 20'h0, 64'h0, 0, 5'd0, 0,  4'h0, 1, 1, 5'd3, 16'h3C00, 0, 5'd0, 16'h0, 32'h0000_0008, 0);
    addVec(4'h0, 20'h0, 64'h0, 1, 5'd7, 0,  4'h0, 1, 0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 32'h0000_0000, 0);
    addVec(4'h0, 20'h0, 64'h0, 1, 5'd9, 0,  4'h0, 1, 0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 32'h0000_0080, 0);
    addVec(4'h0, 20'h0, 64'h0, 1, 5'd10, 0, 4'h0, 1, 0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 32'h0000_0280, 0);
    addVec(4'h8, {5'd10, 5'd0, 5'd0, 5'd0}, 64'h0A0A_0000_0000_0000, 0, 5'd0, 0,
           4'h8, 1, 0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 32'h0000_0680, 0);
    addVec(4'h7, {5'd0, 5'd9, 5'd7, 5'd7}, 64'h0000_0900_0701_0700, 0, 5'd0, 0,
           4'h5, 1, 1, 5'd10, 16'h0A0A, 0, 5'd0, 16'h0, 32'h0000_0680, 0);
    addVec(4'h2, {5'd0, 5'd9, 5'd7, 5'd7}, 64'h0000_0900_0701_0700, 0, 5'd0, 0,
           4'h2, 1, 1, 5'd7, 16'h0700, 1, 5'd9, 16'h0900, 32'h0000_0280, 0);
    addVec(4'h0, 20'h0, 64'h0, 0, 5'd0, 0,  4'h0, 1, 1, 5'd7, 16'h0701, 0, 5'd0, 16'h0, 32'h0000_0000, 0);
    addVec(4'h0, 20'h0, 64'h0, 0, 5'd0, 0,  4'h0, 1, 0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 32'h0000_0000, 0);

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst.ready", 32'(bus.src_ready), 32'h0);
    checkOutput("rst.we0", 32'(bus.we0), 32'h0);
    checkOutput("rst.we1", 32'(bus.we1), 32'h0);
    checkOutput("rst.waddr0", 32'(bus.waddr0), 32'h0);
    checkOutput("rst.wdata1", 32'(bus.wdata1), 32'h0);
    checkOutput("rst.busy", bus.busy_vec, 32'h0);
    checkOutput("rst.wb_err", 32'(bus.wb_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].v, vecs[k].a, vecs[k].d, vecs[k].iv, vecs[k].ia, vecs[k].fl);
      checkRow(k, vecs[k]);
    end

    // Issue stall on r5 until its writeback commits.
    applyStimulus(4'h0, 20'h0, 64'h0, 1'b1, 5'd5, 1'b0);
    checkOutput("stall.first_issue", 32'(bus.issue_ready), 32'h1);
    applyStimulus(4'h0, 20'h0, 64'h0, 1'b1, 5'd5, 1'b0);
    checkOutput("stall.blocked", 32'(bus.issue_ready), 32'h0);
    checkOutput("stall.busy", bus.busy_vec, 32'h0000_0020);
    applyStimulus(4'h2, {5'd0, 5'd0, 5'd5, 5'd0}, 64'h0000_0000_0505_0000, 1'b1, 5'd5, 1'b0);
    checkOutput("stall.blocked2", 32'(bus.issue_ready), 32'h0);
    checkOutput("stall.ready", 32'(bus.src_ready), 32'h2);
    applyStimulus(4'h0, 20'h0, 64'h0, 1'b1, 5'd5, 1'b0);
    checkOutput("stall.blocked3", 32'(bus.issue_ready), 32'h0);
    checkOutput("stall.we0", 32'(bus.we0), 32'h1);
    checkOutput("stall.waddr0", 32'(bus.waddr0), 32'd5);
    checkOutput("stall.wdata0", 32'(bus.wdata0), 32'h0505);
    applyStimulus(4'h0, 20'h0, 64'h0, 1'b1, 5'd5, 1'b0);
    checkOutput("stall.accepted", 32'(bus.issue_ready), 32'h1);
    checkOutput("stall.busy_clear", bus.busy_vec, 32'h0);
    applyStimulus(4'h0, 20'h0, 64'h0, 1'b0, 5'd5, 1'b0);
    checkOutput("stall.busy_set", bus.busy_vec, 32'h0000_0020);

    // Flush with a write in flight, then a late write to a flushed register.
    applyStimulus(4'h0, 20'h0, 64'h0, 1'b1, 5'd14, 1'b0);
    checkOutput("flush.issue14", 32'(bus.issue_ready), 32'h1);
    applyStimulus(4'h8, {5'd14, 5'd0, 5'd0, 5'd0}, 64'h1414_0000_0000_0000, 1'b0, 5'd0, 1'b0);
    checkOutput("flush.ready", 32'(bus.src_ready), 32'h8);
    checkOutput("flush.busy_pre", bus.busy_vec, 32'h0000_4020);
    applyStimulus(4'h0, 20'h0, 64'h0, 1'b1, 5'd6, 1'b1);
    checkOutput("flush.we0", 32'(bus.we0), 32'h1);
    checkOutput("flush.waddr0", 32'(bus.waddr0), 32'd14);
    checkOutput("flush.wdata0", 32'(bus.wdata0), 32'h1414);
    idle();
    checkOutput("flush.busy_post", bus.busy_vec, 32'h0);
    checkOutput("flush.we0_off", 32'(bus.we0), 32'h0);
    checkOutput("flush.wb_err", 32'(bus.wb_err), 32'h0);
    applyStimulus(4'h1, {5'd0, 5'd0, 5'd0, 5'd5}, 64'h0000_0000_0000_5555, 1'b0, 5'd0, 1'b0);
    checkOutput("flush.late_ready", 32'(bus.src_ready), 32'h1);
    idle();
    checkOutput("flush.late_we0", 32'(bus.we0), 32'h1);
    checkOutput("flush.late_waddr0", 32'(bus.waddr0), 32'd5);
    checkOutput("flush.late_err", 32'(bus.wb_err), 32'h0);
    idle();
    checkOutput("flush.late_err2", 32'(bus.wb_err), 32'h0);

    // Writeback to a register that was never issued sets the sticky error.
    applyStimulus(4'h4, {5'd0, 5'd12, 5'd0, 5'd0}, 64'h0000_1212_0000_0000, 1'b0, 5'd0, 1'b0);
    checkOutput("err.ready", 32'(bus.src_ready), 32'h4);
    checkOutput("err.before", 32'(bus.wb_err), 32'h0);
    idle();
    checkOutput("err.we0", 32'(bus.we0), 32'h1);
    checkOutput("err.waddr0", 32'(bus.waddr0), 32'd12);
    checkOutput("err.wdata0", 32'(bus.wdata0), 32'h1212);
    checkOutput("err.set", 32'(bus.wb_err), 32'h1);
    for (int c = 0; c < 3; c++) begin
      idle();
      checkOutput($sformatf("err.sticky%0d", c), 32'(bus.wb_err), 32'h1);
    end

    // Asynchronous reset drops a registered write immediately.
    applyStimulus(4'h1, {5'd0, 5'd0, 5'd0, 5'd1}, 64'h0000_0000_0000_0101, 1'b0, 5'd0, 1'b0);
    checkOutput("areset.ready", 32'(bus.src_ready), 32'h1);
    @(posedge clk);
    #2;
    bus.src_valid = 4'h0;
    checkOutput("areset.we0_pre", 32'(bus.we0), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("areset.we0", 32'(bus.we0), 32'h0);
    checkOutput("areset.err", 32'(bus.wb_err), 32'h0);
    checkOutput("areset.busy", bus.busy_vec, 32'h0);
    checkOutput("areset.ready0", 32'(bus.src_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    checkOutput("areset.we0_post", 32'(bus.we0), 32'h0);
    checkOutput("areset.err_post", 32'(bus.wb_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
